// File: rtl/count_display.sv
// -----------------------------------------------------------------------------
// count_display
//   Display stage for the binary control-unit counter. A small FSM converts the
//   binary count to BCD using the iterative shift-add-3 (double dabble)
//   algorithm, running continuously. Each completed conversion is exported on
//   bcd with a one-cycle valid pulse. The BCD digits drive a multiplexed,
//   common-anode 7-segment display with leading-zero blanking.
//
// Ports
//   clk          in   1           clock, rising edge
//   rst          in   1           synchronous, active-high reset
//   value        in   WIDTH       binary count to display
//   bcd          out  4*DIGITS    last completed conversion, bcd[3:0] = units
//   valid        out  1           one-cycle pulse when bcd is updated
//   an           out  DIGITS      anode enables, active-low, one lit at a time
//   seg          out  7           segments {g,f,e,d,c,b,a}, active-low
//   dbg_state_o  out  2           current conversion FSM state (IDLE/SHIFT/LOAD)
//
// Handshake: valid is a pure strobe with no ready; it is high for exactly the
//   first cycle in which bcd holds a newly completed conversion, and bcd stays
//   stable until the next strobe.
// -----------------------------------------------------------------------------
module count_display #(
    parameter int WIDTH    = 13,
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 5000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      value,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  valid,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg,
    output logic [1:0]            dbg_state_o
);

    localparam int BW = 4 * DIGITS;
    localparam int IW = $clog2(WIDTH + 1);
    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int XW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [IW-1:0] ITER_LAST = IW'(WIDTH - 1);
    localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
    localparam logic [XW-1:0] IDX_MAX   = XW'(DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LOAD  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Conversion FSM
    // ------------------------------------------------------------------
    state_t          state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [BW-1:0]   scratch_q, scratch_d;
    logic [IW-1:0]   iter_q, iter_d;
    logic [BW-1:0]   bcd_q, bcd_d;
    logic            valid_q, valid_d;

    logic [BW-1:0]       adj;
    logic [BW+WIDTH-1:0] cat;

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        scratch_d = scratch_q;
        iter_d    = iter_q;
        bcd_d     = bcd_q;
        valid_d   = 1'b0;
        adj       = scratch_q;
        cat       = '0;

        // Pre-correct every nibble that would overflow past 9 once doubled.
        for (int k = 0; k < DIGITS; k++) begin
            if (scratch_q[4*k +: 4] >= 4'd5) begin
                adj[4*k +: 4] = scratch_q[4*k +: 4] + 4'd3;
            end
        end

        case (state_q)
            IDLE: begin
                shift_d   = value;
                scratch_d = '0;
                iter_d    = '0;
                state_d   = SHIFT;
            end
            SHIFT: begin
                cat       = {adj, shift_q} << 1;
                scratch_d = cat[WIDTH +: BW];
                shift_d   = cat[WIDTH-1:0];
                iter_d    = iter_q + IW'(1);
                if (iter_q == ITER_LAST) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                bcd_d   = scratch_q;
                valid_d = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            scratch_q <= '0;
            iter_q    <= '0;
            bcd_q     <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            scratch_q <= scratch_d;
            iter_q    <= iter_d;
            bcd_q     <= bcd_d;
            valid_q   <= valid_d;
        end
    end

    // ------------------------------------------------------------------
    // Display scan
    // ------------------------------------------------------------------
    logic [PW-1:0]     presc_q, presc_d;
    logic [XW-1:0]     idx_q, idx_d;
    logic [DIGITS-1:0] an_q, an_d;
    logic [6:0]        seg_q, seg_d;
    logic [3:0]        nib;
    logic              upper_nz;

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    always_comb begin
        presc_d  = presc_q + PW'(1);
        idx_d    = idx_q;
        nib      = 4'd0;
        upper_nz = 1'b0;

        if (presc_q == PRESC_MAX) begin
            presc_d = '0;
            idx_d   = (idx_q == IDX_MAX) ? '0 : idx_q + XW'(1);
        end

        // an/seg are computed from the next index and next bcd so that the
        // registered pair always reflects the current digit with no lag.
        for (int j = 0; j < DIGITS; j++) begin
            if (idx_d == XW'(j)) begin
                nib = bcd_d[4*j +: 4];
            end
            if (j >= int'(idx_d) && bcd_d[4*j +: 4] != 4'd0) begin
                upper_nz = 1'b1;
            end
        end

        an_d = ~(DIGITS'(1) << idx_d);
        // Leading-zero blanking: this digit and everything above it is zero.
        if (idx_d != '0 && !upper_nz) begin
            seg_d = 7'b1111111;
        end else begin
            seg_d = seg_of(nib);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
            idx_q   <= '0;
            an_q    <= ~DIGITS'(1);
            seg_q   <= 7'b1000000;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
        end
    end

    assign bcd         = bcd_q;
    assign valid       = valid_q;
    assign an          = an_q;
    assign seg         = seg_q;
    assign dbg_state_o = state_q;

endmodule
